// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// forwarding selects, FSM states, stage-control bundle.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } hctl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_RUN    = 7'b1111_000;
  localparam stage_ctl_t CTL_FREEZE = 7'b0000_001;
  localparam stage_ctl_t CTL_SQUASH = 7'b1111_110;
  localparam stage_ctl_t CTL_BUBBLE = 7'b0011_010;
  localparam stage_ctl_t CTL_RST    = 7'b0000_111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage
// register/hazard info in, stage controls out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_regwen;
  logic       ex_is_load;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic       ex_redirect;
  logic [4:0] mem_rd;
  logic       mem_regwen;
  logic       mem_is_load;
  logic       mem_req;
  logic       dmem_ready;
  logic [4:0] wb_rd;
  logic       wb_regwen;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_regwen, ex_is_load,
    output ex_rs1, ex_rs2, ex_redirect,
    output mem_rd, mem_regwen, mem_is_load,
    output mem_req, dmem_ready, wb_rd, wb_regwen,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  if_id_flush, id_ex_flush, mem_wb_flush,
    input  fwd_a, fwd_b, mem_err,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_regwen, ex_is_load,
    input  ex_rs1, ex_rs2, ex_redirect,
    input  mem_rd, mem_regwen, mem_is_load,
    input  mem_req, dmem_ready, wb_rd, wb_regwen,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
    output if_id_flush, id_ex_flush, mem_wb_flush,
    output fwd_a, fwd_b, mem_err,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX operand forwarding select for one source reg.
// EX/MEM wins over MEM/WB; x0 is never forwarded.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwen_i,
  input  logic       mem_is_load_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_regwen_i,
  output fwd_sel_e   sel_o
);

  logic hit_mem;
  logic hit_wb;

  // Load data is not ready in EX/MEM; it comes via MEM/WB.
  assign hit_mem = mem_regwen_i && (mem_rd_i != 5'd0)
                && !mem_is_load_i
                && (mem_rd_i == ex_rs_i);
  assign hit_wb  = wb_regwen_i && (wb_rd_i != 5'd0)
                && (wb_rd_i == ex_rs_i);

  always_comb begin
    sel_o = FWD_REG;
    if (hit_mem)     sel_o = FWD_EXMEM;
    else if (hit_wb) sel_o = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipe controller: load-use stall, redirect
// squash, dmem freeze with watchdog, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  hctl_state_e      state_q, state_d;
  logic [31:0]      wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_inc, flush_inc;
  logic             load_use, freeze;
  stage_ctl_t       ctl;
  fwd_sel_e         sel_a, sel_b;

  assign freeze   = bus.mem_req && !bus.dmem_ready;
  assign load_use = bus.ex_is_load && bus.ex_regwen
                 && (bus.ex_rd != 5'd0)
                 && ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd)
                  || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ctl       = CTL_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          ctl       = CTL_FREEZE;
          stall_inc = 1'b1;
          state_d   = MEM_WAIT;
        end else if (bus.ex_redirect) begin
          ctl       = CTL_SQUASH;
          flush_inc = 1'b1;
        end else if (load_use) begin
          ctl       = CTL_BUBBLE;
          stall_inc = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          ctl       = CTL_FREEZE;
          stall_inc = 1'b1;
          wait_d    = wait_q + 32'd1;
          if (MEM_TIMEOUT != 0
              && wait_q == 32'(MEM_TIMEOUT - 1))
            state_d = ERROR;
        end
      end
      ERROR: ctl = CTL_FREEZE;
      default: state_d = RUN;
    endcase
    if (rst) ctl = CTL_RST;
  end

  // Saturating perf counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if (flush_inc && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  fwd_unit u_fwd_a (
    .ex_rs_i      (bus.ex_rs1),
    .mem_rd_i     (bus.mem_rd),
    .mem_regwen_i (bus.mem_regwen),
    .mem_is_load_i(bus.mem_is_load),
    .wb_rd_i      (bus.wb_rd),
    .wb_regwen_i  (bus.wb_regwen),
    .sel_o        (sel_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs_i      (bus.ex_rs2),
    .mem_rd_i     (bus.mem_rd),
    .mem_regwen_i (bus.mem_regwen),
    .mem_is_load_i(bus.mem_is_load),
    .wb_rd_i      (bus.wb_rd),
    .wb_regwen_i  (bus.wb_regwen),
    .sel_o        (sel_b)
  );

  assign bus.pc_en        = ctl.pc_en;
  assign bus.if_id_en     = ctl.if_id_en;
  assign bus.id_ex_en     = ctl.id_ex_en;
  assign bus.ex_mem_en    = ctl.ex_mem_en;
  assign bus.if_id_flush  = ctl.if_id_flush;
  assign bus.id_ex_flush  = ctl.id_ex_flush;
  assign bus.mem_wb_flush = ctl.mem_wb_flush;
  assign bus.fwd_a        = sel_a;
  assign bus.fwd_b        = sel_b;
  assign bus.mem_err      = (state_q == ERROR);
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk;
  logic rst;
  bit   chk_on;
  int   n_chk;
  int   n_pass;

  int m_mode;
  int m_wait;
  int m_stall;
  int m_flush;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    hif.id_rs1 = 0; hif.id_rs2 = 0;
    hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
    hif.ex_rd = 0; hif.ex_regwen = 0;
    hif.ex_is_load = 0; hif.ex_rs1 = 0;
    hif.ex_rs2 = 0; hif.ex_redirect = 0;
    hif.mem_rd = 0; hif.mem_regwen = 0;
    hif.mem_is_load = 0; hif.mem_req = 0;
    hif.dmem_ready = 0; hif.wb_rd = 0;
    hif.wb_regwen = 0;
  endtask

  task automatic set_lu(logic [4:0] r);
    hif.ex_is_load = 1; hif.ex_regwen = 1;
    hif.ex_rd = r; hif.id_rs1 = r;
    hif.id_use_rs1 = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    nxt();
    rst = 0;
  endtask

  function automatic int sat(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic int fwd(logic [4:0] rs);
    if (hif.mem_regwen && hif.mem_rd != 0 &&
        !hif.mem_is_load && hif.mem_rd == rs)
      return 1;
    if (hif.wb_regwen && hif.wb_rd != 0 && hif.wb_rd == rs)
      return 2;
    return 0;
  endfunction

  // Model: 0 running, 1 waiting on dmem, 2 dead.
  // Control vector order: pc,ifid,idex,exmem,
  // ifid_fl,idex_fl,memwb_fl.
  always @(negedge clk) begin
    logic [6:0] exp_ctl;
    logic [6:0] act_ctl;
    bit lu;
    bit frz;
    if (chk_on) begin
      lu = hif.ex_is_load && hif.ex_regwen && hif.ex_rd != 0
        && ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd)
         || (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
      frz = hif.mem_req && !hif.dmem_ready;
      if (rst)              exp_ctl = 7'b0000111;
      else if (m_mode == 2) exp_ctl = 7'b0000001;
      else if (m_mode == 1)
        exp_ctl = hif.dmem_ready ? 7'b1111000 : 7'b0000001;
      else if (frz)             exp_ctl = 7'b0000001;
      else if (hif.ex_redirect) exp_ctl = 7'b1111110;
      else if (lu)              exp_ctl = 7'b0011010;
      else                      exp_ctl = 7'b1111000;
      act_ctl = {hif.pc_en, hif.if_id_en, hif.id_ex_en,
                 hif.ex_mem_en, hif.if_id_flush,
                 hif.id_ex_flush, hif.mem_wb_flush};
      chk("m_ctl", int'(act_ctl), int'(exp_ctl));
      chk("m_fwd_a", int'(hif.fwd_a), fwd(hif.ex_rs1));
      chk("m_fwd_b", int'(hif.fwd_b), fwd(hif.ex_rs2));
      chk("m_err", int'(hif.mem_err), (m_mode == 2) ? 1 : 0);
      chk("m_stall", int'(hif.stall_cnt), m_stall);
      chk("m_flush", int'(hif.flush_cnt), m_flush);
      if (rst) begin
        m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end else if (m_mode == 0) begin
        if (frz) begin
          m_stall = sat(m_stall); m_mode = 1;
        end else if (hif.ex_redirect) m_flush = sat(m_flush);
        else if (lu) m_stall = sat(m_stall);
      end else if (m_mode == 1) begin
        if (hif.dmem_ready) begin
          m_mode = 0; m_wait = 0;
        end else begin
          m_stall = sat(m_stall);
          m_wait++;
          if (m_wait >= TO) m_mode = 2;
        end
      end
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; chk_on = 0;
    m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    clr();
    rst = 1;
    nxt();
    chk_on = 1;
    mid();
    chk("rst_pc_en", int'(hif.pc_en), 0);
    chk("rst_ifid_fl", int'(hif.if_id_flush), 1);
    chk("rst_memwb_fl", int'(hif.mem_wb_flush), 1);
    chk("rst_stall", int'(hif.stall_cnt), 0);
    nxt();
    rst = 0;

    // load-use: lw x5 / add x6,x5,x1
    set_lu(5); hif.id_rs2 = 1; hif.id_use_rs2 = 1;
    mid();
    chk("lu_pc_en", int'(hif.pc_en), 0);
    chk("lu_ifid_en", int'(hif.if_id_en), 0);
    chk("lu_idex_fl", int'(hif.id_ex_flush), 1);
    chk("lu_exmem_en", int'(hif.ex_mem_en), 1);
    nxt();
    clr(); hif.id_rs1 = 5; hif.id_use_rs1 = 1;
    hif.mem_rd = 5; hif.mem_regwen = 1;
    hif.mem_is_load = 1; hif.ex_rs1 = 5;
    mid();
    chk("lu_release", int'(hif.pc_en), 1);
    chk("lu_no_fwd_load", int'(hif.fwd_a), 0);
    chk("lu_stall1", int'(hif.stall_cnt), 1);
    nxt();
    clr(); hif.wb_rd = 5; hif.wb_regwen = 1;
    hif.ex_rs1 = 5; hif.ex_rs2 = 1;
    mid();
    chk("lu_fwd_a_wb", int'(hif.fwd_a), 2);
    chk("lu_fwd_b_reg", int'(hif.fwd_b), 0);
    nxt();

    // redirect beats load-use
    do_reset();
    clr(); set_lu(5); hif.ex_redirect = 1;
    mid();
    chk("rd_ifid_fl", int'(hif.if_id_flush), 1);
    chk("rd_idex_fl", int'(hif.id_ex_flush), 1);
    chk("rd_pc_en", int'(hif.pc_en), 1);
    nxt();
    clr();
    mid();
    chk("rd_flush_cnt", int'(hif.flush_cnt), 1);
    chk("rd_stall_cnt", int'(hif.stall_cnt), 0);
    nxt();

    // 3 freeze cycles then release
    do_reset();
    clr(); hif.mem_req = 1; hif.ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("frz_pc_en", int'(hif.pc_en), 0);
      chk("frz_memwb_fl", int'(hif.mem_wb_flush), 1);
      nxt();
      hif.ex_redirect = 0;
    end
    hif.dmem_ready = 1;
    mid();
    chk("frz_rel_pc_en", int'(hif.pc_en), 1);
    chk("frz_rel_memwb", int'(hif.mem_wb_flush), 0);
    nxt();
    clr();
    mid();
    chk("frz_stall3", int'(hif.stall_cnt), 3);
    chk("frz_flush0", int'(hif.flush_cnt), 0);
    nxt();

    // watchdog
    do_reset();
    clr(); hif.mem_req = 1;
    repeat (4) nxt();
    mid();
    chk("wd_not_yet", int'(hif.mem_err), 0);
    nxt();
    mid();
    chk("wd_err", int'(hif.mem_err), 1);
    chk("wd_stall5", int'(hif.stall_cnt), 5);
    clr();
    repeat (2) nxt();
    mid();
    chk("wd_sticky", int'(hif.mem_err), 1);
    chk("wd_pc_en", int'(hif.pc_en), 0);
    chk("wd_frozen", int'(hif.stall_cnt), 5);
    nxt();
    do_reset();
    mid();
    chk("wd_cleared", int'(hif.mem_err), 0);
    chk("wd_stall0", int'(hif.stall_cnt), 0);
    nxt();

    // forwarding priority
    clr(); hif.mem_rd = 7; hif.wb_rd = 7;
    hif.mem_regwen = 1; hif.wb_regwen = 1;
    hif.ex_rs1 = 7; hif.ex_rs2 = 7;
    mid();
    chk("fw_exmem", int'(hif.fwd_a), 1);
    chk("fw_exmem_b", int'(hif.fwd_b), 1);
    hif.mem_rd = 0;
    mid();
    chk("fw_memwb", int'(hif.fwd_a), 2);
    hif.ex_rs1 = 0; hif.wb_rd = 0;
    mid();
    chk("fw_x0", int'(hif.fwd_a), 0);
    nxt();

    // reset inside MEM_WAIT, then saturation
    do_reset();
    clr(); hif.mem_req = 1;
    repeat (2) nxt();
    rst = 1;
    nxt();
    rst = 0; clr();
    mid();
    chk("rw_pc_en", int'(hif.pc_en), 1);
    chk("rw_stall0", int'(hif.stall_cnt), 0);
    nxt();
    set_lu(3);
    repeat (20) nxt();
    clr(); hif.ex_redirect = 1;
    repeat (20) nxt();
    clr();
    mid();
    chk("sat_stall", int'(hif.stall_cnt), 15);
    chk("sat_flush", int'(hif.flush_cnt), 15);
    nxt();

    // random mix against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      hif.id_rs1 = 5'($urandom_range(0, 3));
      hif.id_rs2 = 5'($urandom_range(0, 3));
      hif.id_use_rs1 = 1'($urandom_range(0, 1));
      hif.id_use_rs2 = 1'($urandom_range(0, 1));
      hif.ex_rd = 5'($urandom_range(0, 3));
      hif.ex_regwen = 1'($urandom_range(0, 1));
      hif.ex_is_load = 1'($urandom_range(0, 1));
      hif.ex_rs1 = 5'($urandom_range(0, 3));
      hif.ex_rs2 = 5'($urandom_range(0, 3));
      hif.ex_redirect = ($urandom_range(0, 5) == 0);
      hif.mem_rd = 5'($urandom_range(0, 3));
      hif.mem_regwen = 1'($urandom_range(0, 1));
      hif.mem_is_load = 1'($urandom_range(0, 1));
      hif.mem_req = 1'($urandom_range(0, 1));
      hif.dmem_ready = ($urandom_range(0, 3) != 0);
      hif.wb_rd = 5'($urandom_range(0, 3));
      hif.wb_regwen = 1'($urandom_range(0, 1));
      nxt();
    end

    mid();
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
